// File: rtl/mcycle_ctrl_pkg.sv
// ============================================================================
// Package  : mcycle_ctrl_pkg
// Brief    : Opcodes, state encodings and datapath-select encodings shared by
//            the multi-cycle main control FSM and its output decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mcycle_ctrl_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_NEXEC  = 4'd10,
    S_NWB    = 4'd11,
    S_BLZ    = 4'd12
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_NORI  = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    SRCB_B       = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alusrcb_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_RSVD   = 2'b11
  } pcsource_e;

  typedef enum logic [1:0] {
    REGDST_RT   = 2'b00,
    REGDST_RD   = 2'b01,
    REGDST_RA   = 2'b10,
    REGDST_RSVD = 2'b11
  } regdst_e;

  typedef struct packed {
    logic      pcwrite;
    logic      pcwritecond;
    logic      iord;
    logic      memread;
    logic      memwrite;
    logic      irwrite;
    logic      regwrite;
    logic      alusrca;
    logic      zext;
    logic      memtoreg;
    regdst_e   regdst;
    alusrcb_e  alusrcb;
    pcsource_e pcsource;
    logic      link;
    aluop_e    aluop;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/mcycle_main_control_if.sv
// ============================================================================
// Interface: mcycle_main_control_if
// Brief    : Opcode/handshake inputs and datapath control outputs of the
//            multi-cycle main controller. master = controller, slave = datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mcycle_main_control_if;

  logic [5:0] opcode;
  logic       mem_ready;
  logic       rs_lez;

  logic       pcwrite;
  logic       pcwritecond;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       alusrca;
  logic       zext;
  logic       memtoreg;
  logic [1:0] regdst;
  logic [1:0] alusrcb;
  logic [1:0] pcsource;
  logic       link;
  logic       aluop1;
  logic       aluop0;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready, rs_lez,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite, regwrite,
           alusrca, zext, memtoreg, regdst, alusrcb, pcsource, link,
           aluop1, aluop0, state
  );

  modport slave (
    output opcode, mem_ready, rs_lez,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite, regwrite,
           alusrca, zext, memtoreg, regdst, alusrcb, pcsource, link,
           aluop1, aluop0, state
  );

endinterface

`default_nettype wire

// File: rtl/mcycle_ctrl_outdec.sv
// ============================================================================
// Module   : mcycle_ctrl_outdec
// Brief    : Moore decoder from state (+ mem_ready in FETCH) to control outputs.
//            Macro BLEZAL_EN enables the BLZ state decode.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mcycle_ctrl_outdec
  import mcycle_ctrl_pkg::*;
(
  input  wire logic   reset_i,
  input  wire state_e state_i,
  input  wire logic   mem_ready_i,
  input  wire logic   rs_lez_i,
  output ctrl_t       ctrl_o
);

`ifndef BLEZAL_EN
  logic unused_rs_lez;
  assign unused_rs_lez = rs_lez_i;
`endif

  always_comb begin
    ctrl_o = '0;
    // Outputs are forced low for the whole reset window, not just after it
    if (!reset_i) begin
      case (state_i)
        S_FETCH: begin
          ctrl_o.memread = 1'b1;
          ctrl_o.alusrcb = SRCB_FOUR;
          ctrl_o.aluop   = ALUOP_ADD;
          ctrl_o.irwrite = mem_ready_i;
          ctrl_o.pcwrite = mem_ready_i;
        end
        S_DECODE: begin
          ctrl_o.alusrcb = SRCB_IMM_SH2;
          ctrl_o.aluop   = ALUOP_ADD;
        end
        S_MEMADR: begin
          ctrl_o.alusrca = 1'b1;
          ctrl_o.alusrcb = SRCB_IMM;
          ctrl_o.aluop   = ALUOP_ADD;
        end
        S_MEMRD: begin
          ctrl_o.memread = 1'b1;
          ctrl_o.iord    = 1'b1;
        end
        S_MEMWB: begin
          ctrl_o.regwrite = 1'b1;
          ctrl_o.memtoreg = 1'b1;
          ctrl_o.regdst   = REGDST_RT;
        end
        S_MEMWR: begin
          ctrl_o.memwrite = 1'b1;
          ctrl_o.iord     = 1'b1;
        end
        S_REXEC: begin
          ctrl_o.alusrca = 1'b1;
          ctrl_o.alusrcb = SRCB_B;
          ctrl_o.aluop   = ALUOP_FUNCT;
        end
        S_RWB: begin
          ctrl_o.regwrite = 1'b1;
          ctrl_o.regdst   = REGDST_RD;
        end
        S_BRANCH: begin
          ctrl_o.alusrca     = 1'b1;
          ctrl_o.alusrcb     = SRCB_B;
          ctrl_o.aluop       = ALUOP_SUB;
          ctrl_o.pcwritecond = 1'b1;
          ctrl_o.pcsource    = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          ctrl_o.pcwrite  = 1'b1;
          ctrl_o.pcsource = PCSRC_JUMP;
        end
        S_NEXEC: begin
          ctrl_o.alusrca = 1'b1;
          ctrl_o.alusrcb = SRCB_IMM;
          ctrl_o.zext    = 1'b1;
          ctrl_o.aluop   = ALUOP_NORI;
        end
        S_NWB: begin
          ctrl_o.regwrite = 1'b1;
          ctrl_o.regdst   = REGDST_RT;
        end
`ifdef BLEZAL_EN
        S_BLZ: begin
          ctrl_o.alusrca = 1'b1;
          ctrl_o.alusrcb = SRCB_B;
          ctrl_o.aluop   = ALUOP_SUB;
          // Link and branch commit together only when rs <= 0
          if (rs_lez_i) begin
            ctrl_o.pcwrite  = 1'b1;
            ctrl_o.pcsource = PCSRC_ALUOUT;
            ctrl_o.regwrite = 1'b1;
            ctrl_o.regdst   = REGDST_RA;
            ctrl_o.link     = 1'b1;
          end
        end
`endif
        default: ctrl_o = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mcycle_main_control.sv
// ============================================================================
// Module   : mcycle_main_control
// Brief    : Multi-cycle main control FSM (state register + next-state logic).
//            Macro BLEZAL_EN adds the blezal instruction (BLZ state).
// Revision : 1.0
// ============================================================================
`default_nettype none

module mcycle_main_control
  import mcycle_ctrl_pkg::*;
#(
  parameter logic [5:0] OP_NORI   = 6'b010011,
  parameter logic [5:0] OP_BLEZAL = 6'b010100
) (
  input wire logic              clk,
  input wire logic              reset,
  mcycle_main_control_if.master bus
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if ((bus.opcode == OPC_LW) || (bus.opcode == OPC_SW)) state_d = S_MEMADR;
        else if (bus.opcode == OPC_RTYPE)                     state_d = S_REXEC;
        else if (bus.opcode == OPC_BEQ)                       state_d = S_BRANCH;
        else if (bus.opcode == OPC_J)                         state_d = S_JUMP;
        else if (bus.opcode == OP_NORI)                       state_d = S_NEXEC;
`ifdef BLEZAL_EN
        else if (bus.opcode == OP_BLEZAL)                     state_d = S_BLZ;
`else
        else if (bus.opcode == OP_BLEZAL)                     state_d = S_FETCH;
`endif
        else                                                  state_d = S_FETCH;
      end
      S_MEMADR: state_d = (bus.opcode == OPC_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_REXEC:  state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_NEXEC:  state_d = S_NWB;
      S_NWB:    state_d = S_FETCH;
`ifdef BLEZAL_EN
      S_BLZ:    state_d = S_FETCH;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  mcycle_ctrl_outdec u_outdec (
    .reset_i     (reset),
    .state_i     (state_q),
    .mem_ready_i (bus.mem_ready),
    .rs_lez_i    (bus.rs_lez),
    .ctrl_o      (ctrl)
  );

  assign bus.pcwrite     = ctrl.pcwrite;
  assign bus.pcwritecond = ctrl.pcwritecond;
  assign bus.iord        = ctrl.iord;
  assign bus.memread     = ctrl.memread;
  assign bus.memwrite    = ctrl.memwrite;
  assign bus.irwrite     = ctrl.irwrite;
  assign bus.regwrite    = ctrl.regwrite;
  assign bus.alusrca     = ctrl.alusrca;
  assign bus.zext        = ctrl.zext;
  assign bus.memtoreg    = ctrl.memtoreg;
  assign bus.regdst      = ctrl.regdst;
  assign bus.alusrcb     = ctrl.alusrcb;
  assign bus.pcsource    = ctrl.pcsource;
  assign bus.link        = ctrl.link;
  assign bus.aluop1      = ctrl.aluop[1];
  assign bus.aluop0      = ctrl.aluop[0];
  assign bus.state       = reset ? 4'd0 : state_q;

endmodule

`default_nettype wire
